// File: rtl/dw_kernel_reg.sv
// Double-buffered depthwise kernel register: words stream into a fill bank while the
// depthwise engine reads the other bank; the two banks behave as a two-deep kernel FIFO.
module dw_kernel_reg #(
    parameter int DW    = 32,
    parameter int KSIZE = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DW-1:0]               dw_in,
    input  logic                        dw_valid,
    output logic                        dw_ready,
    output logic [KSIZE*KSIZE*DW-1:0]   k_data,
    output logic                        k_valid,
    input  logic                        k_release,
    output logic                        dw_comp,
    input  logic                        flush
);

    localparam int KN  = KSIZE * KSIZE;
    localparam int WCW = (KN > 1) ? $clog2(KN) : 1;
    localparam int IW  = $clog2(2 * KN);

    // Bank b, word w lives at flat index b*KN + w.
    logic [DW-1:0]  bank_q [2*KN];
    logic [1:0]     full_q, full_d;
    logic           fb_q, fb_d;
    logic           rb_q, rb_d;
    logic [WCW-1:0] wc_q, wc_d;
    logic           dw_comp_q, dw_comp_d;

    logic           accept;
    logic           release_k;
    logic           last_word;
    logic           wr_en;
    logic [IW-1:0]  wr_idx;

    assign dw_ready  = !full_q[fb_q];
    assign k_valid   = full_q[rb_q];
    assign dw_comp   = dw_comp_q;

    assign accept    = dw_valid && dw_ready;
    assign release_k = k_release && k_valid;
    assign last_word = (wc_q == WCW'(KN - 1));
    assign wr_en     = accept && !flush;
    assign wr_idx    = fb_q ? (IW'(KN) + IW'(wc_q)) : IW'(wc_q);

    always_comb begin
        full_d    = full_q;
        fb_d      = fb_q;
        rb_d      = rb_q;
        wc_d      = wc_q;
        dw_comp_d = 1'b0;
        if (flush) begin
            full_d = 2'b00;
            fb_d   = 1'b0;
            rb_d   = 1'b0;
            wc_d   = '0;
        end else begin
            // A fill can only target an empty bank and a release only a full one,
            // so both updates touch different bits of full when they coincide.
            if (accept) begin
                if (last_word) begin
                    full_d[fb_q] = 1'b1;
                    wc_d         = '0;
                    fb_d         = !fb_q;
                end else begin
                    wc_d = wc_q + WCW'(1);
                end
            end
            if (release_k) begin
                full_d[rb_q] = 1'b0;
                rb_d         = !rb_q;
                dw_comp_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 2'b00;
            fb_q      <= 1'b0;
            rb_q      <= 1'b0;
            wc_q      <= '0;
            dw_comp_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            fb_q      <= fb_d;
            rb_q      <= rb_d;
            wc_q      <= wc_d;
            dw_comp_q <= dw_comp_d;
        end
    end

    // Flush leaves contents alone; the cleared flags keep stale words from being used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2*KN; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_en) begin
            bank_q[wr_idx] <= dw_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < KN; gi++) begin : g_kdata
            assign k_data[gi*DW +: DW] = rb_q ? bank_q[KN + gi] : bank_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_dw_kernel_reg.sv
// Directed bench for dw_kernel_reg: a two-deep kernel FIFO model is compared on every
// falling edge, and literal kernel contents are checked at key points of each scenario.
module tb_dw_kernel_reg;

    localparam int DW    = 32;
    localparam int KSIZE = 3;
    localparam int KN    = KSIZE * KSIZE;
    localparam int KW    = KN * DW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  dw_in = '0;
    logic           dw_valid = 1'b0;
    logic           dw_ready;
    logic [KW-1:0]  k_data;
    logic           k_valid;
    logic           k_release = 1'b0;
    logic           dw_comp;
    logic           flush = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    dw_kernel_reg #(.DW(DW), .KSIZE(KSIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dw_in     (dw_in),
        .dw_valid  (dw_valid),
        .dw_ready  (dw_ready),
        .k_data    (k_data),
        .k_valid   (k_valid),
        .k_release (k_release),
        .dw_comp   (dw_comp),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    // Model: completed kernels form a FIFO of at most two, plus the partial kernel.
    logic [KW-1:0] mk_q[$];
    logic [DW-1:0] mp_q[$];
    bit            m_comp = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mk_q.delete();
                mp_q.delete();
                m_comp = 1'b0;
            end else if (flush) begin
                mk_q.delete();
                mp_q.delete();
                m_comp = 1'b0;
            end else begin
                bit rel;
                bit acc;
                logic [KW-1:0] v;
                rel = k_release && (mk_q.size() > 0);
                acc = dw_valid && (mk_q.size() < 2);
                if (rel) void'(mk_q.pop_front());
                if (acc) begin
                    mp_q.push_back(dw_in);
                    if (mp_q.size() == KN) begin
                        v = '0;
                        for (int i = 0; i < KN; i++) v[i*DW +: DW] = mp_q[i];
                        mk_q.push_back(v);
                        mp_q.delete();
                    end
                end
                m_comp = rel;
            end
        end
    end

    task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("model_dw_ready", KW'(dw_ready), KW'(mk_q.size() < 2));
            chk("model_k_valid",  KW'(k_valid),  KW'(mk_q.size() > 0));
            chk("model_dw_comp",  KW'(dw_comp),  KW'(m_comp));
            if (mk_q.size() > 0) chk("model_k_data", k_data, mk_q[0]);
        end
    end

    // Literal kernel whose word i equals base+i.
    task automatic chk_words(input string nm, input int base);
        logic [KW-1:0] e;
        e = '0;
        for (int i = 0; i < KN; i++) e[i*DW +: DW] = DW'(base + i);
        chk(nm, k_data, e);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_word(input int w);
        int n;
        dw_valid = 1'b1;
        dw_in    = DW'(w);
        n = 0;
        while (!dw_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            miscompares++;
            vectors++;
            $display("FAIL send_timeout: got dw_ready=0 expected 1 within 100 cycles (word %0d)", w);
        end
        @(negedge clk);
        dw_valid = 1'b0;
    endtask

    task automatic send_range(input int first, input int last);
        for (int w = first; w <= last; w++) send_word(w);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic pulse_release();
        k_release = 1'b1;
        @(negedge clk);
        k_release = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held for three cycles.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_k_valid",  KW'(k_valid),  KW'(0));
        chk("rst_k_data",   k_data,        KW'(0));
        chk("rst_dw_comp",  KW'(dw_comp),  KW'(0));
        chk("rst_dw_ready", KW'(dw_ready), KW'(1));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_dw_ready", KW'(dw_ready), KW'(1));

        // Single kernel, back to back.
        send_range(1, 8);
        chk("single_not_valid_8", KW'(k_valid), KW'(0));
        send_word(9);
        chk("single_valid",      KW'(k_valid),  KW'(1));
        chk("single_ready",      KW'(dw_ready), KW'(1));
        chk_words("single_kdata", 1);

        // Backpressure: both banks full, word 19 held across the release.
        pulse_flush();
        send_range(1, 18);
        chk("bp_ready_low", KW'(dw_ready), KW'(0));
        chk_words("bp_kdata_bank0", 1);
        dw_valid = 1'b1;
        dw_in    = DW'(19);
        repeat (3) @(negedge clk);
        chk("bp_still_blocked", KW'(dw_ready), KW'(0));
        k_release = 1'b1;
        @(negedge clk);
        k_release = 1'b0;
        chk("bp_comp_pulse", KW'(dw_comp),  KW'(1));
        chk("bp_ready_back", KW'(dw_ready), KW'(1));
        chk_words("bp_kdata_bank1", 10);
        @(negedge clk);
        dw_valid = 1'b0;
        chk("bp_comp_single", KW'(dw_comp), KW'(0));
        send_range(20, 27);
        chk("bp_third_ready_low", KW'(dw_ready), KW'(0));
        pulse_release();
        chk_words("bp_kdata_19_27", 19);

        // Last word of bank 1 coincides with release of bank 0.
        pulse_flush();
        send_range(1, 17);
        dw_valid  = 1'b1;
        dw_in     = DW'(18);
        k_release = 1'b1;
        @(negedge clk);
        dw_valid  = 1'b0;
        k_release = 1'b0;
        chk("sim_valid", KW'(k_valid), KW'(1));
        chk("sim_comp",  KW'(dw_comp), KW'(1));
        chk_words("sim_kdata_bank1", 10);
        @(negedge clk);
        chk("sim_comp_once", KW'(dw_comp), KW'(0));

        // Release while nothing is valid is ignored.
        pulse_flush();
        pulse_release();
        chk("idle_release_no_comp", KW'(dw_comp), KW'(0));

        // Flush discards a partial kernel.
        send_range(50, 53);
        pulse_flush();
        send_range(100, 107);
        chk("flush_not_valid", KW'(k_valid), KW'(0));
        send_word(108);
        chk("flush_valid", KW'(k_valid), KW'(1));
        chk_words("flush_kdata", 100);

        // Flush beats a simultaneous release and acceptance.
        dw_valid  = 1'b1;
        dw_in     = DW'(77);
        k_release = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        dw_valid  = 1'b0;
        k_release = 1'b0;
        flush     = 1'b0;
        chk("flush_prio_comp",  KW'(dw_comp), KW'(0));
        chk("flush_prio_valid", KW'(k_valid), KW'(0));

        // Gapped stream with idle cycles between words.
        for (int w = 30; w < 39; w++) begin
            send_word(w);
            repeat (w % 3) @(negedge clk);
        end
        chk_words("gapped_kdata", 30);

        // Reset mid-fill: only post-reset words form the next kernel.
        pulse_flush();
        send_range(60, 64);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_kdata_zero", k_data, KW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_range(200, 207);
        chk("midrst_not_valid", KW'(k_valid), KW'(0));
        send_word(208);
        chk("midrst_valid", KW'(k_valid), KW'(1));
        chk_words("midrst_kdata", 200);
        pulse_release();
        chk("midrst_comp", KW'(dw_comp), KW'(1));

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
